// File: rtl/cholesky_reconstruct.sv
// Rebuilds A = L*L^T from a lower-triangular double-precision factor using one shared
// multiplier and one shared adder, accumulating each element strictly in k order.
module fpu (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  rmode,
    input  logic [2:0]  fpu_op,
    input  logic [63:0] opa,
    input  logic [63:0] opb,
    output logic [63:0] out,
    output logic        ready,
    output logic        underflow,
    output logic        overflow,
    output logic        inexact,
    output logic        exception,
    output logic        invalid
);
    // Double-precision add/sub/mul; ready pulses two cycles after enable.
    // Subnormal results flush to signed zero; op codes with bit 2 set return qNaN.
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    logic [63:0] a_q, b_q;
    logic [2:0]  op_q;
    logic [1:0]  rm_q;
    logic        pend_q;

    logic        sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge;
    logic        special, inv, rs, g, st, up, ovf, unf;
    logic [52:0] ma, mb, big_m, sm_m, mant;
    logic signed [12:0] ea_e, eb_e, big_e, sm_e, ediff, re, re2;
    logic [5:0]   sh, lz;
    logic [105:0] prod;
    logic [110:0] ext;
    logic [55:0]  bm, al, nrm;
    logic [56:0]  sum;
    logic [53:0]  rnd;
    logic [63:0]  spec_val, res;

    always_comb begin
        sa      = a_q[63];
        sb      = b_q[63] ^ (op_q == 3'b001);
        ma      = {|a_q[62:52], a_q[51:0]};
        mb      = {|b_q[62:52], b_q[51:0]};
        ea_e    = (a_q[62:52] == 11'd0) ? 13'sd1 : $signed({2'b00, a_q[62:52]});
        eb_e    = (b_q[62:52] == 11'd0) ? 13'sd1 : $signed({2'b00, b_q[62:52]});
        a_nan   = (&a_q[62:52]) & (|a_q[51:0]);
        b_nan   = (&b_q[62:52]) & (|b_q[51:0]);
        a_inf   = (&a_q[62:52]) & ~(|a_q[51:0]);
        b_inf   = (&b_q[62:52]) & ~(|b_q[51:0]);
        a_zero  = ~(|a_q[62:0]);
        b_zero  = ~(|b_q[62:0]);
        a_ge    = (a_q[62:0] >= b_q[62:0]);
        special = 1'b0;
        spec_val = '0;
        inv     = 1'b0;
        rs      = 1'b0;
        re      = '0;
        mant    = '0;
        g       = 1'b0;
        st      = 1'b0;
        prod    = '0;
        big_m   = '0;
        sm_m    = '0;
        big_e   = '0;
        sm_e    = '0;
        ediff   = '0;
        sh      = '0;
        ext     = '0;
        bm      = '0;
        al      = '0;
        sum     = '0;
        nrm     = '0;
        lz      = '0;
        if (op_q[2]) begin
            special = 1'b1; spec_val = QNAN; inv = 1'b1;
        end else if (op_q[1]) begin
            rs = sa ^ sb;
            if (a_nan | b_nan) begin
                special = 1'b1; spec_val = QNAN;
            end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
                special = 1'b1; spec_val = QNAN; inv = 1'b1;
            end else if (a_inf | b_inf) begin
                special = 1'b1; spec_val = {rs, 11'h7FF, 52'd0};
            end else if (a_zero | b_zero) begin
                special = 1'b1; spec_val = {rs, 63'd0};
            end else begin
                prod = ma * mb;
                re   = ea_e + eb_e - 13'sd1023;
                if (prod[105]) begin
                    mant = prod[105:53]; g = prod[52]; st = |prod[51:0]; re = re + 13'sd1;
                end else begin
                    mant = prod[104:52]; g = prod[51]; st = |prod[50:0];
                end
            end
        end else begin
            if (a_nan | b_nan) begin
                special = 1'b1; spec_val = QNAN;
            end else if (a_inf & b_inf & (sa != sb)) begin
                special = 1'b1; spec_val = QNAN; inv = 1'b1;
            end else if (a_inf) begin
                special = 1'b1; spec_val = {sa, a_q[62:0]};
            end else if (b_inf) begin
                special = 1'b1; spec_val = {sb, b_q[62:0]};
            end else begin
                big_m = a_ge ? ma : mb;
                sm_m  = a_ge ? mb : ma;
                big_e = a_ge ? ea_e : eb_e;
                sm_e  = a_ge ? eb_e : ea_e;
                rs    = a_ge ? sa : sb;
                ediff = big_e - sm_e;
                sh    = (ediff > 13'sd60) ? 6'd60 : ediff[5:0];
                // Three extra low bits carry guard/round/sticky through the alignment.
                ext   = {sm_m, 58'd0} >> sh;
                al    = {ext[110:56], ext[55] | (|ext[54:0])};
                bm    = {big_m, 3'b000};
                sum   = (sa == sb) ? ({1'b0, bm} + {1'b0, al}) : ({1'b0, bm} - {1'b0, al});
                if (sum == 57'd0) begin
                    special = 1'b1; spec_val = {sa & sb, 63'd0};
                end else if (sum[56]) begin
                    nrm = {sum[56:2], sum[1] | sum[0]}; re = big_e + 13'sd1;
                end else begin
                    for (int n = 0; n < 56; n++) if (sum[n]) lz = 6'(55 - n);
                    nrm = sum[55:0] << lz;
                    re  = big_e - $signed({7'd0, lz});
                end
                mant = nrm[55:3]; g = nrm[2]; st = |nrm[1:0];
            end
        end
        case (rm_q)
            2'b00:   up = g & (st | mant[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = (g | st) & ~rs;
            default: up = (g | st) & rs;
        endcase
        rnd = {1'b0, mant} + {53'd0, up};
        re2 = rnd[53] ? re + 13'sd1 : re;
        ovf = ~special & (re2 >= 13'sd2047);
        unf = ~special & (re2 <= 13'sd0);
        if (special)  res = spec_val;
        else if (ovf) res = {rs, 11'h7FF, 52'd0};
        else if (unf) res = {rs, 63'd0};
        else          res = {rs, re2[10:0], rnd[53] ? rnd[52:1] : rnd[51:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0; b_q <= '0; op_q <= '0; rm_q <= '0; pend_q <= 1'b0;
            out <= '0; ready <= 1'b0;
            underflow <= 1'b0; overflow <= 1'b0; inexact <= 1'b0;
            exception <= 1'b0; invalid <= 1'b0;
        end else begin
            pend_q <= enable;
            ready  <= pend_q;
            if (enable) begin
                a_q <= opa; b_q <= opb; op_q <= fpu_op; rm_q <= rmode;
            end
            if (pend_q) begin
                out       <= res;
                underflow <= unf;
                overflow  <= ovf;
                inexact   <= ~special & (g | st | ovf | unf);
                invalid   <= inv;
                exception <= inv | ovf | unf;
            end
        end
    end
endmodule

module cholesky_reconstruct #(
    parameter int SIZE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [SIZE*SIZE*64-1:0] factor,
    output logic [SIZE*SIZE*64-1:0] matrix,
    output logic                   busy,
    output logic                   ready,
    output logic [2:0]             dbg_state_o
);
    typedef enum logic [2:0] {IDLE = 3'd0, MUL = 3'd1, ACC = 3'd2, STORE = 3'd3, DONE = 3'd4} state_t;

    state_t state_q, state_d;
    logic [3:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [63:0] acc_q, acc_d, prod_q, prod_d;
    logic [SIZE*SIZE*64-1:0] factor_q, factor_d, matrix_q, matrix_d;
    logic        issued_q, issued_d, busy_q, busy_d, ready_q, ready_d;
    logic        mul_en, add_en, mul_rdy, add_rdy;
    logic [63:0] l_ik, l_jk, mul_out, add_out;
    logic [4:0]  mul_flags_unused, add_flags_unused;

    // Only k<=j<=i is ever addressed, so upper-triangle factor bits are never read.
    assign l_ik = factor_q[(int'(i_q) * SIZE + int'(k_q)) * 64 +: 64];
    assign l_jk = factor_q[(int'(j_q) * SIZE + int'(k_q)) * 64 +: 64];

    fpu u_mul (
        .clk(clk), .rst(rst), .enable(mul_en), .rmode(2'b00), .fpu_op(3'b010),
        .opa(l_ik), .opb(l_jk), .out(mul_out), .ready(mul_rdy),
        .underflow(mul_flags_unused[0]), .overflow(mul_flags_unused[1]),
        .inexact(mul_flags_unused[2]), .exception(mul_flags_unused[3]),
        .invalid(mul_flags_unused[4])
    );

    fpu u_add (
        .clk(clk), .rst(rst), .enable(add_en), .rmode(2'b00), .fpu_op(3'b000),
        .opa(acc_q), .opb(prod_q), .out(add_out), .ready(add_rdy),
        .underflow(add_flags_unused[0]), .overflow(add_flags_unused[1]),
        .inexact(add_flags_unused[2]), .exception(add_flags_unused[3]),
        .invalid(add_flags_unused[4])
    );

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        factor_d = factor_q;
        matrix_d = matrix_q;
        issued_d = issued_q;
        busy_d   = busy_q;
        ready_d  = ready_q;
        mul_en   = 1'b0;
        add_en   = 1'b0;
        case (state_q)
            IDLE: if (enable) begin
                factor_d = factor;
                i_d = '0; j_d = '0; k_d = '0; acc_d = '0;
                issued_d = 1'b0; busy_d = 1'b1; ready_d = 1'b0;
                state_d = MUL;
            end
            MUL: begin
                // issued_q keeps the operator enable to a single cycle while waiting.
                if (!issued_q) begin
                    mul_en = 1'b1; issued_d = 1'b1;
                end
                if (mul_rdy) begin
                    prod_d = mul_out; issued_d = 1'b0; state_d = ACC;
                end
            end
            ACC: begin
                if (!issued_q) begin
                    add_en = 1'b1; issued_d = 1'b1;
                end
                if (add_rdy) begin
                    acc_d = add_out; issued_d = 1'b0;
                    if (k_q < j_q) begin
                        k_d = k_q + 4'd1; state_d = MUL;
                    end else begin
                        state_d = STORE;
                    end
                end
            end
            STORE: begin
                matrix_d[(int'(i_q) * SIZE + int'(j_q)) * 64 +: 64] = acc_q;
                matrix_d[(int'(j_q) * SIZE + int'(i_q)) * 64 +: 64] = acc_q;
                if (j_q < i_q) begin
                    j_d = j_q + 4'd1; k_d = '0; acc_d = '0; state_d = MUL;
                end else if (i_q < 4'(SIZE - 1)) begin
                    i_d = i_q + 4'd1; j_d = '0; k_d = '0; acc_d = '0; state_d = MUL;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d = 1'b0; ready_d = 1'b1; state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            i_q <= '0; j_q <= '0; k_q <= '0;
            acc_q <= '0; prod_q <= '0;
            factor_q <= '0; matrix_q <= '0;
            issued_q <= 1'b0; busy_q <= 1'b0; ready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q <= i_d; j_q <= j_d; k_q <= k_d;
            acc_q <= acc_d; prod_q <= prod_d;
            factor_q <= factor_d; matrix_q <= matrix_d;
            issued_q <= issued_d; busy_q <= busy_d; ready_q <= ready_d;
        end
    end

    assign matrix      = matrix_q;
    assign busy        = busy_q;
    assign ready       = ready_q;
    assign dbg_state_o = state_q;
endmodule
